// File: rtl/fsquare_pkg.sv
// Shared FP32 definitions for the FPU datapath units.
// Field widths, exponent bias and the special encodings the units saturate or flush to.
package fsquare_pkg;

  localparam int FP32_W  = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int SIG_W   = MAN_W + 1;
  localparam int PROD_W  = 2 * SIG_W;
  localparam int BIAS    = 127;

  localparam logic [FP32_W-1:0] FP32_PINF  = 32'h7F80_0000;
  localparam logic [FP32_W-1:0] FP32_PZERO = 32'h0000_0000;

  // Operand side-band that travels alongside the significand/product.
  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic             zflag;
    logic             iflag;
  } op_info_t;

endpackage

// File: rtl/fsquare_round.sv
// Normalize, round half-up and classify a significand square into an FP32 result.
// Purely combinational; shared with the fmul datapath.
module fsquare_round
  import fsquare_pkg::*;
(
  input  logic [PROD_W-1:0] p,
  input  logic [EXP_W-1:0]  e,
  input  logic              zflag,
  input  logic              iflag,
  output logic [FP32_W-1:0] y,
  output logic              ovf,
  output logic              udf
);

  logic             n;
  logic [MAN_W-1:0] frac;
  logic             guard;
  logic [MAN_W:0]   frac_sum;
  logic             c;
  logic signed [9:0] e_res;
  logic             unused_bits;

  assign n     = p[PROD_W-1];
  assign frac  = n ? p[46:24] : p[45:23];
  assign guard = n ? p[23] : p[22];

  assign frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, guard};
  assign c        = frac_sum[MAN_W];

  // 2*E fits in 9 bits; a 10-bit signed result covers -127..385 without wrap.
  assign e_res = $signed({1'b0, e, 1'b0}) - 10'sd127
               + $signed({9'b0, n}) + $signed({9'b0, c});

  assign unused_bits = ^{p[21:0], e_res[9:8]};

  always_comb begin
    y   = FP32_PZERO;
    ovf = 1'b0;
    udf = 1'b0;
    if (zflag) begin
      y = FP32_PZERO;
    end else if (iflag || (e_res >= 10'sd255)) begin
      y   = FP32_PINF;
      ovf = 1'b1;
    end else if (e_res <= 10'sd0) begin
      y   = FP32_PZERO;
      udf = 1'b1;
    end else begin
      y = {1'b0, e_res[7:0], frac_sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fsquare_pipe.sv
// Three-stage FP32 squarer y = x*x with valid/ready streaming and whole-pipe stall.
// Stage 1 unpacks the operand, stage 2 holds the significand product, stage 3 the result.
module fsquare_pipe
  import fsquare_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [FP32_W-1:0] x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FP32_W-1:0] y,
  output logic              ovf,
  output logic              udf,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              stall;
  logic              v1;
  logic              v2;
  logic [SIG_W-1:0]  m1;
  op_info_t          info1;
  op_info_t          info2;
  logic [PROD_W-1:0] p2;
  logic [FP32_W-1:0] y_nxt;
  logic              ovf_nxt;
  logic              udf_nxt;
  logic              unused_sign;

  assign stall       = out_valid & ~out_ready;
  assign in_ready    = ~stall;
  assign unused_sign = x[FP32_W-1];

  // Payload is reset as well so idle slots never carry X into the result stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      m1        <= '0;
      info1     <= '0;
      info2     <= '0;
      p2        <= '0;
      y         <= FP32_PZERO;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (!stall) begin
      v1          <= in_valid;
      m1          <= {1'b1, x[MAN_W-1:0]};
      info1.e     <= x[30:23];
      info1.zflag <= (x[30:23] == 8'h00);
      info1.iflag <= (x[30:23] == 8'hFF);

      v2    <= v1;
      p2    <= {{SIG_W{1'b0}}, m1} * {{SIG_W{1'b0}}, m1};
      info2 <= info1;

      out_valid <= v2;
      y         <= y_nxt;
      ovf       <= ovf_nxt;
      udf       <= udf_nxt;
    end
  end

  fsquare_round u_round (
    .p     (p2),
    .e     (info2.e),
    .zflag (info2.zflag),
    .iflag (info2.iflag),
    .y     (y_nxt),
    .ovf   (ovf_nxt),
    .udf   (udf_nxt)
  );

endmodule

// File: tb/tb_fsquare_pipe.sv
// Directed self-checking bench for fsquare_pipe: latency, streaming, rounding,
// flags, back-pressure and mid-flight reset.
module tb_fsquare_pipe;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        udf;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_fail;

  fsquare_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .udf       (udf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Push one item into an empty pipe, measure latency and check the result.
  task automatic run_one(input string tag, input logic [31:0] xin,
                         input logic [31:0] exp_y, input logic exp_ovf, input logic exp_udf);
    int lat;
    out_ready = 1'b1;
    x         = xin;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    x        = 32'h0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_y"}, y, exp_y);
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_udf"}, 32'(udf), 32'(exp_udf));
    cycle();
  endtask

  logic [31:0] bp_x [5];
  logic [31:0] bp_y [5];
  int sent;
  int got;
  int cyc;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    x         = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    cycle();

    // Single item latency
    run_one("two", 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0);

    // Back-to-back stream, sign ignored
    x = 32'h3FC0_0000; in_valid = 1'b1; cycle();
    x = 32'h4040_0000; cycle();
    x = 32'hC040_0000; cycle();
    in_valid = 1'b0; x = 32'h0;
    chk("strm0_valid", 32'(out_valid), 32'd1);
    chk("strm0_y", y, 32'h4010_0000);
    cycle();
    chk("strm1_valid", 32'(out_valid), 32'd1);
    chk("strm1_y", y, 32'h4110_0000);
    cycle();
    chk("strm2_valid", 32'(out_valid), 32'd1);
    chk("strm2_y", y, 32'h4110_0000);
    cycle();
    chk("strm_drained", 32'(out_valid), 32'd0);

    // Rounding and n=0 / n=1 normalization
    run_one("rnd_up", 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0);
    run_one("rnd_dn", 32'h3F7F_FFFF, 32'h3F7F_FFFE, 1'b0, 1'b0);

    // Flags and flushing
    run_one("ovf", 32'h6000_0000, 32'h7F80_0000, 1'b1, 1'b0);
    run_one("udf", 32'h1F00_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_one("denorm", 32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_one("nan", 32'h7FC0_0000, 32'h7F80_0000, 1'b1, 1'b0);

    // Back-pressure: out_ready low for cycles 3..6 while 5 items stream in
    bp_x[0] = 32'h4000_0000; bp_y[0] = 32'h4080_0000;
    bp_x[1] = 32'h3FC0_0000; bp_y[1] = 32'h4010_0000;
    bp_x[2] = 32'h4040_0000; bp_y[2] = 32'h4110_0000;
    bp_x[3] = 32'h3F80_0001; bp_y[3] = 32'h3F80_0002;
    bp_x[4] = 32'h3F7F_FFFF; bp_y[4] = 32'h3F7F_FFFE;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 5 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 5);
      if (sent < 5) x = bp_x[sent];
      else          x = 32'h0;
      #1;
      if (!out_ready) begin
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_y_held", y, bp_y[got]);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_order", y, bp_y[got]);
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 32'h0;
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_got", 32'(got), 32'd5);
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    cycle();

    // Reset with three items in flight
    x = 32'h6000_0000; in_valid = 1'b1; cycle();
    x = 32'h4000_0000; cycle();
    x = 32'h4040_0000; cycle();
    in_valid = 1'b0; x = 32'h0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    rstn = 1'b0;
    cycle();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    run_one("post_rst", 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0);
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
